// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   WORD_W   : data/address word width
//   GRANT_IF : grant encoding for the instruction-fetch port
//   GRANT_DM : grant encoding for the data port
//   state_t  : arbiter FSM states
package mem_arb_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch port, the data port and the memory.
//   if_*        : instruction-fetch request/response
//   dm_*        : data request/response
//   mem_*       : memory-side transaction
//   addr_sel    : registered grant (1 = data port, 0 = fetch port)
//   timeout_err : sticky abort flag
// Modports: master = arbiter side, slave = requesters/memory side.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic              if_req;
    logic [WORD_W-1:0] if_addr;
    logic              if_ack;
    logic [WORD_W-1:0] if_rdata;

    logic              dm_req;
    logic              dm_we;
    logic [WORD_W-1:0] dm_addr;
    logic [WORD_W-1:0] dm_wdata;
    logic              dm_ack;
    logic [WORD_W-1:0] dm_rdata;

    logic              mem_valid;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [WORD_W-1:0] mem_rdata;

    logic              addr_sel;
    logic              timeout_err;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_ready, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata,
        output mem_valid, mem_we, mem_addr, mem_wdata,
        output addr_sel, timeout_err
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output mem_ready, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata,
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        input  addr_sel, timeout_err
    );

endinterface

// File: rtl/mem_port_arbiter_mux.sv
// 32-bit 2:1 multiplexer.
//   op1    : selected when sel = 1
//   op2    : selected when sel = 0
//   sel    : select
//   result : selected operand
module mem_port_arbiter_mux
    import mem_arb_pkg::*;
(
    input  logic [WORD_W-1:0] op1,
    input  logic [WORD_W-1:0] op2,
    input  logic              sel,
    output logic [WORD_W-1:0] result
);

    assign result = sel ? op1 : op2;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto a single memory port.
// One transaction at a time: IDLE grants and captures, BUSY waits for
// mem_ready (or times out after MAX_WAIT cycles), RESP pulses the ack.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : requester/memory bundle (master modport)
// Parameters:
//   DATA_PRIORITY : 1 = data port wins ties, 0 = round-robin on ties
//   MAX_WAIT      : BUSY cycles without mem_ready before abort (1..255)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_PRIORITY = 1,
    parameter int MAX_WAIT      = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.master bus
);

    // Last BUSY cycle index that may still end without mem_ready.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t            state;
    logic [7:0]        wait_cnt;
    logic              last_grant;
    logic              grant;
    logic              we_q;
    logic              timeout_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] if_rdata_q;
    logic [WORD_W-1:0] dm_rdata_q;

    logic              next_grant;
    logic [WORD_W-1:0] next_addr;

    // Grant choice, only consumed in IDLE.
    always_comb begin
        next_grant = GRANT_IF;
        if (bus.if_req && bus.dm_req) begin
            if (DATA_PRIORITY != 0) begin
                next_grant = GRANT_DM;
            end else begin
                next_grant = ~last_grant;
            end
        end else if (bus.dm_req) begin
            next_grant = GRANT_DM;
        end
    end

    mem_port_arbiter_mux u_addr_mux (
        .op1    (bus.dm_addr),
        .op2    (bus.if_addr),
        .sel    (next_grant),
        .result (next_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            last_grant <= GRANT_DM;
            grant      <= GRANT_IF;
            we_q       <= 1'b0;
            timeout_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.if_req || bus.dm_req) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        addr_q     <= next_addr;
                        // A fetch never writes; wdata only tracks the data port.
                        we_q       <= (next_grant == GRANT_DM) && bus.dm_we;
                        if (next_grant == GRANT_DM) begin
                            wdata_q <= bus.dm_wdata;
                        end
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.mem_ready) begin
                        if (grant == GRANT_DM) begin
                            dm_rdata_q <= bus.mem_rdata;
                        end else begin
                            if_rdata_q <= bus.mem_rdata;
                        end
                        state <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        if (grant == GRANT_DM) begin
                            dm_rdata_q <= '0;
                        end else begin
                            if_rdata_q <= '0;
                        end
                        timeout_q <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                RESP: begin
                    wait_cnt <= '0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_valid   = (state == BUSY);
    assign bus.mem_we      = (state == BUSY) && we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.addr_sel    = grant;
    assign bus.timeout_err = timeout_q;
    assign bus.if_ack      = (state == RESP) && (grant == GRANT_IF);
    assign bus.dm_ack      = (state == RESP) && (grant == GRANT_DM);
    assign bus.if_rdata    = if_rdata_q;
    assign bus.dm_rdata    = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a data-priority instance with a
// programmable-delay memory model and a round-robin instance with a
// zero-wait memory. Expected completions are queued when requests are driven
// and compared when the corresponding ack appears.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        logic        port;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    exp_t sb_rr[$];

    int mem_delay;   // BUSY cycle (1-based) that sees mem_ready; 0 = never
    int busy_cnt;
    logic if_hold;   // keep if_req high across acks

    mem_port_arbiter_if bus();
    mem_port_arbiter_if bus_rr();

    mem_port_arbiter #(.DATA_PRIORITY(1), .MAX_WAIT(15)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    mem_port_arbiter #(.DATA_PRIORITY(0), .MAX_WAIT(15)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_rr.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return (a == 32'h40) ? 32'h1234_5678 : ((a ^ 32'hC0DE_0000) + 32'd7);
    endfunction

    function automatic exp_t mk(input logic p, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.port = p;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model for the data-priority instance.
    always @(negedge clk) begin
        if (bus.mem_valid) begin
            busy_cnt      = busy_cnt + 1;
            bus.mem_ready = (busy_cnt == mem_delay);
            bus.mem_rdata = rd_word(bus.mem_addr);
        end else begin
            busy_cnt      = 0;
            bus.mem_ready = 1'b0;
            bus.mem_rdata = '0;
        end
    end

    // Zero-wait memory for the round-robin instance.
    always @(negedge clk) begin
        bus_rr.mem_ready = 1'b1;
        bus_rr.mem_rdata = rd_word(bus_rr.mem_addr);
    end

    // Scoreboard and requester release, data-priority instance.
    always @(negedge clk) begin
        exp_t e;
        if (bus.if_ack || bus.dm_ack) begin
            chk("main_one_ack", 32'(bus.if_ack & bus.dm_ack), 32'd0);
            if (sb.size() == 0) begin
                chk("main_spurious_ack", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                chk("main_port", 32'(bus.dm_ack), 32'(e.port));
                chk("main_sel", 32'(bus.addr_sel), 32'(e.port));
                chk("main_addr", bus.mem_addr, e.addr);
                chk("main_rdata", bus.dm_ack ? bus.dm_rdata : bus.if_rdata, e.data);
            end
            if (bus.if_ack && !if_hold) bus.if_req = 1'b0;
            if (bus.dm_ack) bus.dm_req = 1'b0;
        end
        if (bus.mem_we) begin
            chk("we_in_busy", 32'(bus.mem_valid), 32'd1);
            chk("we_dm_only", 32'(bus.addr_sel), 32'(GRANT_DM));
        end
    end

    // Scoreboard and requester release, round-robin instance.
    always @(negedge clk) begin
        exp_t e;
        if (bus_rr.if_ack || bus_rr.dm_ack) begin
            chk("rr_one_ack", 32'(bus_rr.if_ack & bus_rr.dm_ack), 32'd0);
            if (sb_rr.size() == 0) begin
                chk("rr_spurious_ack", 32'(sb_rr.size()), 32'd1);
            end else begin
                e = sb_rr.pop_front();
                chk("rr_port", 32'(bus_rr.dm_ack), 32'(e.port));
                chk("rr_addr", bus_rr.mem_addr, e.addr);
                chk("rr_rdata", bus_rr.dm_ack ? bus_rr.dm_rdata : bus_rr.if_rdata, e.data);
            end
            if (bus_rr.if_ack) bus_rr.if_req = 1'b0;
            if (bus_rr.dm_ack) bus_rr.dm_req = 1'b0;
        end
    end

    // Call right after driving a request on a falling edge.
    task automatic wait_ack(output int lat, output int we_cyc);
        lat    = 0;
        we_cyc = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.mem_we) we_cyc++;
            if (bus.if_ack || bus.dm_ack) return;
        end
        chk("ack_timeout", 32'(lat), 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && sb_rr.size() == 0 &&
                !bus.mem_valid && !bus_rr.mem_valid &&
                !bus.if_ack && !bus.dm_ack && !bus_rr.if_ack && !bus_rr.dm_ack)
                return;
        end
        chk("drain_timeout", 32'(sb.size() + sb_rr.size()), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, 32'({bus.if_ack, bus.dm_ack, bus.mem_valid, bus.mem_we,
                               bus.addr_sel, bus.timeout_err}), 32'd0);
        chk({tag, "_addr"}, bus.mem_addr, 32'd0);
        chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_if_rdata"}, bus.if_rdata, 32'd0);
        chk({tag, "_dm_rdata"}, bus.dm_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int wec;

        rst_n     = 1'b0;
        if_hold   = 1'b0;
        mem_delay = 1;
        busy_cnt  = 0;
        bus.if_req = 1'b0;    bus.if_addr = '0;
        bus.dm_req = 1'b0;    bus.dm_we   = 1'b0;
        bus.dm_addr = '0;     bus.dm_wdata = '0;
        bus_rr.if_req = 1'b0; bus_rr.if_addr = '0;
        bus_rr.dm_req = 1'b0; bus_rr.dm_we   = 1'b0;
        bus_rr.dm_addr = '0;  bus_rr.dm_wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_zero("rst");
        chk("rst_rr_ctl", 32'({bus_rr.if_ack, bus_rr.dm_ack, bus_rr.mem_valid,
                               bus_rr.addr_sel, bus_rr.timeout_err}), 32'd0);
        rst_n = 1'b1;

        // Lone fetch, zero-wait memory
        @(negedge clk);
        mem_delay   = 1;
        bus.if_addr = 32'h0000_0040;
        bus.if_req  = 1'b1;
        sb.push_back(mk(GRANT_IF, 32'h40, 32'h1234_5678));
        wait_ack(lat, wec);
        chk("fetch_lat", 32'(lat), 32'd2);
        chk("fetch_sel", 32'(bus.addr_sel), 32'd0);
        chk("fetch_rdata", bus.if_rdata, 32'h1234_5678);
        drain();

        // Simultaneous requests on both instances
        @(negedge clk);
        bus.if_addr = 32'h200; bus.dm_addr = 32'h300; bus.dm_we = 1'b0;
        bus.if_req  = 1'b1;    bus.dm_req  = 1'b1;
        bus_rr.if_addr = 32'h200; bus_rr.dm_addr = 32'h300;
        bus_rr.if_req  = 1'b1;    bus_rr.dm_req  = 1'b1;
        sb.push_back(mk(GRANT_DM, 32'h300, rd_word(32'h300)));
        sb.push_back(mk(GRANT_IF, 32'h200, rd_word(32'h200)));
        sb_rr.push_back(mk(GRANT_IF, 32'h200, rd_word(32'h200)));
        sb_rr.push_back(mk(GRANT_DM, 32'h300, rd_word(32'h300)));
        drain();

        // Round-robin: after a fetch, the next tie goes to data
        @(negedge clk);
        bus_rr.if_addr = 32'h600; bus_rr.if_req = 1'b1;
        sb_rr.push_back(mk(GRANT_IF, 32'h600, rd_word(32'h600)));
        drain();
        @(negedge clk);
        bus_rr.if_addr = 32'h610; bus_rr.dm_addr = 32'h620;
        bus_rr.if_req  = 1'b1;    bus_rr.dm_req  = 1'b1;
        sb_rr.push_back(mk(GRANT_DM, 32'h620, rd_word(32'h620)));
        sb_rr.push_back(mk(GRANT_IF, 32'h610, rd_word(32'h610)));
        drain();

        // Data write with 3-cycle memory
        @(negedge clk);
        mem_delay    = 3;
        bus.dm_addr  = 32'h100;
        bus.dm_wdata = 32'hDEAD_BEEF;
        bus.dm_we    = 1'b1;
        bus.dm_req   = 1'b1;
        sb.push_back(mk(GRANT_DM, 32'h100, rd_word(32'h100)));
        wait_ack(lat, wec);
        chk("wr_lat", 32'(lat), 32'd4);
        chk("wr_we_cycles", 32'(wec), 32'd3);
        chk("wr_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        chk("wr_if_ack", 32'(bus.if_ack), 32'd0);
        drain();
        bus.dm_we = 1'b0;

        // Timeout: memory never ready
        @(negedge clk);
        mem_delay   = 0;
        bus.if_addr = 32'h80;
        bus.if_req  = 1'b1;
        sb.push_back(mk(GRANT_IF, 32'h80, 32'h0));
        wait_ack(lat, wec);
        chk("to_lat", 32'(lat), 32'd16);
        chk("to_rdata", bus.if_rdata, 32'h0);
        chk("to_err", 32'(bus.timeout_err), 32'd1);
        drain();

        // Reset mid-BUSY, request held through it
        @(negedge clk);
        chk("to_sticky", 32'(bus.timeout_err), 32'd1);
        mem_delay   = 8;
        bus.dm_addr = 32'h400;
        bus.dm_we   = 1'b0;
        bus.dm_req  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pre_busy", 32'(bus.mem_valid), 32'd1);
        rst_n     = 1'b0;
        mem_delay = 2;
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(mk(GRANT_DM, 32'h400, rd_word(32'h400)));
        wait_ack(lat, wec);
        chk("rst_resume_lat", 32'(lat), 32'd3);
        drain();

        // Back-to-back fetches with req held
        @(negedge clk);
        mem_delay   = 1;
        if_hold     = 1'b1;
        bus.if_addr = 32'h500;
        bus.if_req  = 1'b1;
        for (int t = 0; t < 3; t++) sb.push_back(mk(GRANT_IF, 32'h500, rd_word(32'h500)));
        wait_ack(lat, wec);
        chk("b2b_lat", 32'(lat), 32'd2);
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            chk("b2b_idle", 32'({bus.mem_valid, bus.if_ack}), 32'd0);
            @(negedge clk);
            chk("b2b_busy", 32'(bus.mem_valid), 32'd1);
            if (t == 1) if_hold = 1'b0;
            @(negedge clk);
            chk("b2b_ack", 32'(bus.if_ack), 32'd1);
        end
        drain();

        chk("sb_main_left", 32'(sb.size()), 32'd0);
        chk("sb_rr_left", 32'(sb_rr.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
